// File: rtl/hazard_scoreboard_pkg.sv
// hazard_scoreboard_pkg: shared register width, pipeline tag slot type and bubble constant
package hazard_scoreboard_pkg;

    localparam int REG_W = 4;

    typedef struct packed {
        logic             valid;
        logic             wb_en;
        logic             mem_read;
        logic [REG_W-1:0] dest;
    } slot_t;

    localparam slot_t BUBBLE = '0;

endpackage

// File: rtl/hazard_scoreboard_if.sv
// hazard_scoreboard_if: ID-stage request, stall decision and per-stage forwarding tags
interface hazard_scoreboard_if #(parameter int CNT_W = 16);

    logic                                   id_valid;
    logic [hazard_scoreboard_pkg::REG_W-1:0] id_src1;
    logic [hazard_scoreboard_pkg::REG_W-1:0] id_src2;
    logic                                   id_two_src;
    logic [hazard_scoreboard_pkg::REG_W-1:0] id_dest;
    logic                                   id_wb_en;
    logic                                   id_mem_read;
    logic                                   enable_forward;
    logic                                   flush;
    logic                                   hazard_stall;
    logic [hazard_scoreboard_pkg::REG_W-1:0] exe_dest;
    logic [hazard_scoreboard_pkg::REG_W-1:0] mem_dest;
    logic [hazard_scoreboard_pkg::REG_W-1:0] wb_dest;
    logic                                   exe_wb_en;
    logic                                   mem_wb_en;
    logic                                   wb_wb_en;
    logic [CNT_W-1:0]                       stall_count;

    modport master (
        output id_valid, id_src1, id_src2, id_two_src, id_dest, id_wb_en, id_mem_read,
               enable_forward, flush,
        input  hazard_stall, exe_dest, mem_dest, wb_dest, exe_wb_en, mem_wb_en, wb_wb_en,
               stall_count
    );

    modport slave (
        input  id_valid, id_src1, id_src2, id_two_src, id_dest, id_wb_en, id_mem_read,
               enable_forward, flush,
        output hazard_stall, exe_dest, mem_dest, wb_dest, exe_wb_en, mem_wb_en, wb_wb_en,
               stall_count
    );

endinterface

// File: rtl/hazard_scoreboard_tag_match.sv
// tag_match: a source register hits a slot when that slot holds a live write to it
module tag_match
    import hazard_scoreboard_pkg::*;
(
    input  logic [REG_W-1:0] src,
    input  slot_t            slot,
    output logic             match
);

    assign match = slot.valid && slot.wb_en && (src == slot.dest);

endmodule

// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard: tracks in-flight destinations in EXE/MEM/WB and stalls ID on RAW hazards
module hazard_scoreboard
    import hazard_scoreboard_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input logic                clk,
    input logic                rst,
    hazard_scoreboard_if.slave sb
);

    slot_t            exe;
    slot_t            mem;
    slot_t            wb;
    logic [CNT_W-1:0] cnt;
    logic             s1_exe;
    logic             s1_mem;
    logic             s2_exe;
    logic             s2_mem;
    logic             hit_exe;
    logic             hit_mem;
    logic             unused_mem_read;

    tag_match u_s1_exe (.src(sb.id_src1), .slot(exe), .match(s1_exe));
    tag_match u_s1_mem (.src(sb.id_src1), .slot(mem), .match(s1_mem));
    tag_match u_s2_exe (.src(sb.id_src2), .slot(exe), .match(s2_exe));
    tag_match u_s2_mem (.src(sb.id_src2), .slot(mem), .match(s2_mem));

    assign hit_exe = s1_exe || (sb.id_two_src && s2_exe);
    assign hit_mem = s1_mem || (sb.id_two_src && s2_mem);

    // WB never stalls: the register file writes in the first half and reads in the second
    assign sb.hazard_stall = sb.id_valid && !sb.flush &&
                             (sb.enable_forward ? (hit_exe && exe.mem_read) : (hit_exe || hit_mem));

    // Advance the tag pipeline; a stalled or flushed ID slot enters EXE as a bubble
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            exe <= BUBBLE;
            mem <= BUBBLE;
            wb  <= BUBBLE;
        end else begin
            wb  <= mem;
            mem <= exe;
            exe <= (!sb.hazard_stall && !sb.flush)
                   ? slot_t'{sb.id_valid, sb.id_wb_en, sb.id_mem_read, sb.id_dest}
                   : BUBBLE;
        end
    end

    // Saturating count of stalled cycles
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            cnt <= '0;
        else if (sb.hazard_stall && cnt != '1)
            cnt <= cnt + 1'b1;
    end

    assign sb.exe_dest    = exe.dest;
    assign sb.mem_dest    = mem.dest;
    assign sb.wb_dest     = wb.dest;
    assign sb.exe_wb_en   = exe.valid && exe.wb_en;
    assign sb.mem_wb_en   = mem.valid && mem.wb_en;
    assign sb.wb_wb_en    = wb.valid && wb.wb_en;
    assign sb.stall_count = cnt;

    assign unused_mem_read = mem.mem_read ^ wb.mem_read;

endmodule
